// File: rtl/uart_rx.sv
// Purpose : 16x-oversampled UART receiver. It uses a 2-FF input synchronizer, a 3-sample
//           majority vote per bit, start-glitch rejection, and framing-error detection.
// Latency : about 9.5 bit-times from the start-bit falling edge to oValid, plus 2-3 iClk
//           cycles of synchronizer delay.
// Backpr. : none. oValid/oFrameErr are one-cycle pulses, and oData holds the last word.
// Ports   : iClk/iRst (asynchronous, active-low) clock and reset; iTick16x is the
//           oversampling strobe; iRx is the async serial line (idle high); oData is the
//           last received word; oValid marks a good frame; oFrameErr marks a low stop bit;
//           oBusy is high when the FSM is not idle.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iTick16x,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oFrameErr,
    output logic                 oBusy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    // Tick counts where the three vote samples are taken, and the bit-boundary count.
    localparam logic [TW-1:0] C_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] C_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] C_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [TW-1:0]        r_tick_cnt, w_tick_nxt;
    logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_s0, w_s0_nxt;
    logic                 r_s1, w_s1_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_rx_meta, r_rx_sync;
    logic                 w_rxs;
    logic                 w_vote;

    // The synchronizer resets to 1 so that a reset release never looks like a start edge.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= iRx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rxs = r_rx_sync;

    // The third sample is the live synchronized value at the decision tick.
    assign w_vote = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_data     <= w_data_nxt;
            r_s0       <= w_s0_nxt;
            r_s1       <= w_s1_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_s0_nxt    = r_s0;
        w_s1_nxt    = r_s1;
        // Pulses default low, so they clear on the next clock even without a tick.
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        if (iTick16x) begin
            if (r_tick_cnt == C_S0) w_s0_nxt = w_rxs;
            if (r_tick_cnt == C_S1) w_s1_nxt = w_rxs;

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == C_S2 && w_vote) begin
                        // The line went high again before mid-bit, so treat it as noise.
                        w_state_nxt = S_IDLE;
                        w_tick_nxt  = '0;
                    end else if (r_tick_cnt == C_LAST) begin
                        w_state_nxt = S_DATA;
                        w_tick_nxt  = '0;
                        w_bit_nxt   = '0;
                    end
                end
                S_DATA: begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == C_S2) begin
                        w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                    end
                    if (r_tick_cnt == C_LAST) begin
                        w_tick_nxt = '0;
                        w_bit_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == B_LAST) w_state_nxt = S_STOP;
                    end
                end
                S_STOP: begin
                    w_tick_nxt = r_tick_cnt + 1'b1;
                    if (r_tick_cnt == C_S2) begin
                        w_data_nxt = r_shift;
                        w_tick_nxt = '0;
                        // Leave at mid-stop-bit so that the next start edge is not missed.
                        if (w_vote) begin
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high, so a held-low line cannot retrigger.
                    if (w_rxs) w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end
            endcase
        end
    end

    assign oData     = r_data;
    assign oValid    = r_valid;
    assign oFrameErr = r_ferr;
    assign oBusy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : self-checking bench for uart_rx, using directed and random frames against a
//           frame-level reference model.
// Latency : one tick every 10 clocks and one bit every 160 clocks.
// Backpr. : none. The bench only drives the serial line and watches the output pulses.
module tb_uart_rx;
    logic       iClk     = 1'b0;
    logic       iRst     = 1'b0;
    logic       iTick16x = 1'b0;
    logic       iRx      = 1'b1;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oBusy;

    localparam int BIT_CLKS = 160;

    typedef struct {
        bit         ferr;
        logic [7:0] d;
    } ev_t;

    // The model's view: each frame sent produces one event (a good word or a framing
    // error), and both kinds of event load oData.
    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         obs_rd      = 0;
    int         both_cnt    = 0;
    int         busy_cycles = 0;
    logic [7:0] last_data   = 8'h00;
    int         n_chk       = 0;
    int         n_err       = 0;

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iTick16x (iTick16x),
        .iRx      (iRx),
        .oData    (oData),
        .oValid   (oValid),
        .oFrameErr(oFrameErr),
        .oBusy    (oBusy)
    );

    always #5 iClk = ~iClk;

    initial begin
        forever begin
            repeat (9) @(negedge iClk);
            iTick16x = 1'b1;
            @(negedge iClk);
            iTick16x = 1'b0;
        end
    end

    // Record every cycle in which a pulse is high. A two-cycle pulse therefore shows up as
    // an extra event.
    always @(negedge iClk) begin
        ev_t e;
        if (oBusy) busy_cycles = busy_cycles + 1;
        if (oValid && oFrameErr) both_cnt = both_cnt + 1;
        if (oValid || oFrameErr) begin
            e.ferr = oFrameErr;
            e.d    = oData;
            obs_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_bit(input logic b, input bit glitch);
        iRx = b;
        if (glitch) begin
            // Invert the line for one tick period near mid-bit.
            repeat (90) @(negedge iClk);
            iRx = ~b;
            repeat (10) @(negedge iClk);
            iRx = b;
            repeat (BIT_CLKS - 100) @(negedge iClk);
        end else begin
            repeat (BIT_CLKS) @(negedge iClk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic [7:0] gmask);
        ev_t e;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], gmask[i]);
        drive_bit(stop, 1'b0);
        e.ferr = ~stop;
        e.d    = d;
        exp_q.push_back(e);
        last_data = d;
    endtask

    task automatic compare_events(input string tag);
        int n_obs;
        int n;
        n_obs = obs_q.size() - obs_rd;
        check($sformatf("%s_count", tag), 32'(n_obs), 32'(exp_q.size()));
        n = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_kind%0d", tag, i), 32'(obs_q[obs_rd + i].ferr), 32'(exp_q[i].ferr));
            check($sformatf("%s_data%0d", tag, i), 32'(obs_q[obs_rd + i].d), 32'(exp_q[i].d));
        end
        check($sformatf("%s_hold", tag), 32'(oData), 32'(last_data));
        check($sformatf("%s_excl", tag), 32'(both_cnt), 32'd0);
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check($sformatf("%s_data", tag), 32'(oData), 32'd0);
        check($sformatf("%s_valid", tag), 32'(oValid), 32'd0);
        check($sformatf("%s_ferr", tag), 32'(oFrameErr), 32'd0);
        check($sformatf("%s_busy", tag), 32'(oBusy), 32'd0);
    endtask

    initial begin
        int         b0;
        logic [7:0] d;
        logic       good;
        logic [7:0] gm;

        // Reset state.
        repeat (5) @(negedge iClk);
        check_outputs_zero("reset");
        iRst = 1'b1;
        repeat (50) @(negedge iClk);

        // 1: single good frame.
        send_frame(8'hA5, 1'b1, 8'h00);
        repeat (20) @(negedge iClk);
        compare_events("t1");
        check("t1_busy_idle", 32'(oBusy), 32'd0);

        // 2: back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 8'h00);
        send_frame(8'hFF, 1'b1, 8'h00);
        repeat (20) @(negedge iClk);
        compare_events("t2");

        // 3: a short low pulse is rejected as a start glitch.
        b0 = busy_cycles;
        iRx = 1'b0;
        repeat (40) @(negedge iClk);
        iRx = 1'b1;
        repeat (200) @(negedge iClk);
        check("t3_busy_seen", 32'(busy_cycles > b0), 32'd1);
        check("t3_busy_idle", 32'(oBusy), 32'd0);
        compare_events("t3");

        // 4: low stop bit, line held low, then recovery.
        send_frame(8'h3C, 1'b0, 8'h00);
        repeat (3 * BIT_CLKS) @(negedge iClk);
        check("t4_busy_break", 32'(oBusy), 32'd1);
        iRx = 1'b1;
        repeat (40) @(negedge iClk);
        check("t4_busy_idle", 32'(oBusy), 32'd0);
        compare_events("t4a");
        send_frame(8'h55, 1'b1, 8'h00);
        repeat (20) @(negedge iClk);
        compare_events("t4b");

        // 5: single-tick glitch in every data bit.
        send_frame(8'h96, 1'b1, 8'hFF);
        repeat (20) @(negedge iClk);
        compare_events("t5");

        // 6: reset during data bit 4 aborts the frame.
        d = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        iRx = d[4];
        repeat (80) @(negedge iClk);
        iRst = 1'b0;
        iRx  = 1'b1;
        repeat (3) @(negedge iClk);
        check_outputs_zero("t6_rst");
        last_data = 8'h00;
        iRst = 1'b1;
        repeat (200) @(negedge iClk);
        compare_events("t6a");
        send_frame(8'hC3, 1'b1, 8'h00);
        repeat (20) @(negedge iClk);
        compare_events("t6b");

        // Random frames: random data, glitches, stop-bit errors and gaps.
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            gm   = 8'($urandom_range(0, 255));
            send_frame(d, good, gm);
            iRx = 1'b1;
            if (good) repeat ($urandom_range(0, 100)) @(negedge iClk);
            else      repeat ($urandom_range(20, 150)) @(negedge iClk);
        end
        repeat (50) @(negedge iClk);
        compare_events("rand");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver. It consumes the oTick16x strobe from baud_rate_gen and deserializes the asynchronous iRx line into parallel bytes.
- Sits directly downstream of baud_rate_gen and feeds the RX FIFO or register interface.
- Provides start-bit glitch rejection, 3-sample majority voting per bit, and framing-error detection.

Parameters:
- DATA_BITS, 8: data bits per frame, LSB first. Legal range 5..9.
- OVERSAMPLE, 16: ticks per bit. Must match the baud_rate_gen 16x ratio.

Ports:
- iClk, input, 1: system clock, rising edge.
- iRst, input, 1: asynchronous, active-low reset (0 = reset asserted).
- iTick16x, input, 1: one-cycle strobe from baud_rate_gen oTick16x.
- iRx, input, 1: serial line, idle high, asynchronous to iClk.
- oData, output, DATA_BITS: last received word. Held until the next frame completes.
- oValid, output, 1: one-cycle pulse when oData is updated by a good frame.
- oFrameErr, output, 1: one-cycle pulse when the stop bit samples low.
- oBusy, output, 1: high in every state except IDLE.

Behaviour:
- Reset (iRst=0, asynchronous):
  - state=IDLE, tick counter=0, bit counter=0, shift register=0.
  - oData=0, oValid=0, oFrameErr=0, oBusy=0.
  - Both synchronizer flops are set to 1 (line idle).
  - Reset asserted mid-frame aborts the frame; no oValid or oFrameErr pulse is produced.
- iRx passes through a 2-FF synchronizer; all logic uses the synchronized value rxs.
- All state and counter updates occur only on cycles with iTick16x=1, except the output pulses, which clear on the next iClk cycle.
- Tick counter is 4 bits (log2 OVERSAMPLE). It wraps 15->0 at each bit boundary.
- Majority vote: rxs is captured at tick counts 7, 8 and 9. The bit value is 1 if at least two of the three captures are 1. The decision is made at count 9.
- States:
  - IDLE: on a tick with rxs=0, go to START with counter=0.
  - START: at count 9, if the vote is 1 (glitch), return to IDLE. Otherwise continue. At count 15, go to DATA with counter=0 and bit counter=0.
  - DATA: at count 9, shift the vote into the shift register, LSB first (new bit enters the MSB, shift right). At count 15, increment the bit counter. After DATA_BITS bits, go to STOP.
  - STOP: at count 9, load oData from the shift register in both cases below.
    - Vote=1: pulse oValid and go to IDLE. The remainder of the stop bit is not waited out, which allows back-to-back frames.
    - Vote=0: pulse oFrameErr and go to BREAK.
  - BREAK: remain until a tick with rxs=1, then go to IDLE. This prevents a held-low line from retriggering reception.
- Output timing:
  - oValid and oFrameErr are registered. They are high for exactly one iClk cycle, beginning the cycle after the count-9 tick of STOP.
  - They are never high simultaneously.
- Latency: about 9.5 bit-times from the start-bit falling edge to oValid, plus 2-3 iClk cycles of synchronizer delay.
- iTick16x stuck low: the FSM freezes in its current state. This is not an error.
- oBusy is combinational from state (state != IDLE).

Test Plan (CLK_FREQ=16000 and BAUD_RATE=100 in baud_rate_gen, so iTick16x fires every 10 clocks and one bit lasts 160 clocks):
1. Reset, then drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one oValid pulse, oData=0xA5, oFrameErr never high, oBusy returns to 0.
2. Two back-to-back frames 0x00 then 0xFF with no idle gap -> two oValid pulses, oData=0x00 then 0xFF, no frame error.
3. iRx low for 40 clocks (4 ticks) from idle -> FSM returns to IDLE at START count 9; no oValid or oFrameErr pulse; oBusy drops.
4. Frame 0x3C with stop bit driven 0 and iRx held low for 3 further bit-times -> one oFrameErr pulse, oData=0x3C, no oValid, oBusy stays 1 until iRx returns high, then 0x55 is received correctly.
5. Frame 0x96 with a single-tick-wide inverted glitch on iRx at count 8 of every data bit -> majority vote rejects the glitches; oData=0x96 with oValid.
6. Assert iRst=0 during data bit 4 of frame 0x5A, release it, then send 0xC3 -> no pulse for the aborted frame, all outputs 0 during reset, 0xC3 received with oValid.
